user_mgr_arbiter: RTL
=====================

# user_mgr_arbiter

Round-robin arbiter that shares the single user-domain OBI manager port between `NumMgr` user managers, e.g. the CNN accelerator plus a future DMA or debug master. It sits between the user managers and the user manager port of the user domain, replacing the direct CNN-to-port connection. It forwards one A-channel request at a time, tracks in-order outstanding transactions and routes each R-channel response back to its issuer.

## Interface
- `NumMgr`, default 2: number of requesting managers, ≥2.
- `MaxTrans`, default 2: maximum outstanding transactions on the shared port, ≥1.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `in_req_i`  in  NumMgr  per-manager A-channel request.
- `in_gnt_o`  out  NumMgr  per-manager grant.
- `in_addr_i`  in  NumMgr×32  per-manager address.
- `in_we_i`  in  NumMgr  per-manager write enable.
- `in_be_i`  in  NumMgr×4  per-manager byte enables.
- `in_wdata_i`  in  NumMgr×32  per-manager write data.
- `in_rvalid_o`  out  NumMgr  per-manager response valid.
- `in_rdata_o`  out  32  response data, broadcast to all managers.
- `in_err_o`  out  1  response error, broadcast to all managers.
- `out_req_o`, `out_addr_o`, `out_we_o`, `out_be_o`, `out_wdata_o`  out  1/32/1/4/32  shared A channel.
- `out_gnt_i`  in  1  shared grant.
- `out_rvalid_i`, `out_rdata_i`, `out_err_i`  in  1/32/1  shared R channel.
- `unexp_rsp_o`  out  1  one-cycle pulse when `out_rvalid_i` arrives with no transaction outstanding.

## Operation
- **Eligibility.** Manager i is eligible when `in_req_i[i]` is high and the ID FIFO is not full.
- **Arbitration.** Round-robin starting from pointer `rr_q`, searching i = rr_q, rr_q+1, … modulo NumMgr. The first eligible manager is `sel`.
- **A channel.** `out_req_o` is high when any manager is eligible. The `out_*` fields are driven from `sel`. `in_gnt_o[sel]` equals `out_gnt_i & out_req_o`; all other grants are 0.
- **Lock.** When `out_req_o` is high and `out_gnt_i` is low, set `lock_q` and store `sel` in `lock_idx_q`. While locked, `sel` is `lock_idx_q` regardless of other requests, so the downstream request stays stable. The lock clears on the handshake.
- **Handshake** (`out_req_o & out_gnt_i`):
  - push `sel` into the ID FIFO;
  - set `rr_q` to `sel+1` modulo NumMgr.
- **R channel.**
  - When `out_rvalid_i` is high and the FIFO is non-empty, drive `in_rvalid_o[head]` high and pop the FIFO.
  - `out_rdata_i` and `out_err_i` pass to `in_rdata_o` and `in_err_o` unchanged.
- **FIFO.** Depth MaxTrans, each entry clog2(NumMgr) bits wide, with a count 0..MaxTrans. Pointers wrap modulo MaxTrans.
- **Full.** When count == MaxTrans, `out_req_o` is 0, even if a pop occurs in the same cycle. Selection is based on the registered count only.
- **Simultaneous push and pop.** Count is unchanged and both pointers advance.
- **Unexpected response.** `out_rvalid_i` with an empty FIFO: all `in_rvalid_o` stay 0, `unexp_rsp_o` pulses for one cycle, and FIFO state is unchanged.
- **Mid-transaction full.** If the FIFO becomes full while `lock_q` is set, which is only possible at reset, the lock is held and `out_req_o` drops. This is a legal OBI violation only across reset.

## Timing
- The A channel and the R channel are combinational pass-throughs with zero added latency.
- State is `rr_q`, `lock_q`, `lock_idx_q`, the FIFO storage, its pointers and count. All state updates on the `clk_i` rising edge.
- **Reset values:** `rr_q`=0, `lock_q`=0, count=0, pointers=0.
- **Outputs during reset.** While `rst_i` is high, `out_req_o`, `in_gnt_o`, `in_rvalid_o` and `unexp_rsp_o` are forced to 0. `out_*` data fields, `in_rdata_o` and `in_err_o` are don't-care.
- **Reset mid-operation.** All outstanding IDs are discarded. Responses arriving after reset release are flagged via `unexp_rsp_o`.
- **Throughput.** One grant per cycle is sustainable when `out_gnt_i` is held high and responses return with one-cycle latency, provided MaxTrans ≥ 2.

## Test plan
- **Single requester.** Only `in_req_i[0]` high, addr 0x2000_0000, `out_gnt_i`=1, `out_rvalid_i` one cycle later with rdata 0xDEADBEEF → `in_gnt_o`=01 in cycle 0; `in_rvalid_o`=01 with data 0xDEADBEEF in cycle 1.
- **Round-robin.** Both managers request continuously, `out_gnt_i`=1, immediate responses → grants alternate 01, 10, 01, 10. Each `in_rvalid_o` matches the grant order.
- **Lock under backpressure.** Mgr0 requests with `out_gnt_i`=0 for 3 cycles; mgr1 rises in cycle 1 → `out_addr_o` stays mgr0's address for all 3 cycles. Mgr0 is granted in cycle 3 and mgr1 in the next cycle.
- **Full FIFO.** MaxTrans=2, two grants issued, no rvalid → `out_req_o`=0 in cycle 2. After one `out_rvalid_i`, `out_req_o` returns to 1 in the following cycle.
- **Unexpected response.** `out_rvalid_i`=1 with count 0 → `unexp_rsp_o` pulses once, `in_rvalid_o`=00, count stays 0.
- **Reset mid-flight.** `rst_i` is asserted with 2 transactions outstanding and lock set → after release, count=0, `rr_q`=0, and the first stray rvalid raises `unexp_rsp_o`.

Source files
------------

// File: rtl/user_mgr_arbiter_if.sv
// Bundles the per-manager OBI ports and the shared user-domain OBI manager port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface user_mgr_arbiter_if #(
   parameter int unsigned NumMgr   = 2,
   parameter int unsigned MaxTrans = 2
);
   logic [NumMgr-1:0]         in_req_i;
   logic [NumMgr-1:0]         in_gnt_o;
   logic [NumMgr-1:0][31:0]   in_addr_i;
   logic [NumMgr-1:0]         in_we_i;
   logic [NumMgr-1:0][3:0]    in_be_i;
   logic [NumMgr-1:0][31:0]   in_wdata_i;
   logic [NumMgr-1:0]         in_rvalid_o;
   logic [31:0]               in_rdata_o;
   logic                      in_err_o;

   logic                      out_req_o;
   logic [31:0]               out_addr_o;
   logic                      out_we_o;
   logic [3:0]                out_be_o;
   logic [31:0]               out_wdata_o;
   logic                      out_gnt_i;
   logic                      out_rvalid_i;
   logic [31:0]               out_rdata_i;
   logic                      out_err_i;

   modport slave (
      input  in_req_i, in_addr_i, in_we_i, in_be_i, in_wdata_i,
      input  out_gnt_i, out_rvalid_i, out_rdata_i, out_err_i,
      output in_gnt_o, in_rvalid_o, in_rdata_o, in_err_o,
      output out_req_o, out_addr_o, out_we_o, out_be_o, out_wdata_o
   );

   modport master (
      output in_req_i, in_addr_i, in_we_i, in_be_i, in_wdata_i,
      output out_gnt_i, out_rvalid_i, out_rdata_i, out_err_i,
      input  in_gnt_o, in_rvalid_o, in_rdata_o, in_err_o,
      input  out_req_o, out_addr_o, out_we_o, out_be_o, out_wdata_o
   );
endinterface

// File: rtl/user_mgr_arbiter.sv
// Round-robin arbiter sharing one OBI manager port between NumMgr user managers,
// with an in-order ID FIFO that routes each response back to its issuer.
module user_mgr_arbiter #(
   parameter int unsigned NumMgr   = 2,
   parameter int unsigned MaxTrans = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   user_mgr_arbiter_if.slave       bus,
   output logic                    unexp_rsp_o
);

   localparam int unsigned IdW  = (NumMgr > 1)   ? $clog2(NumMgr)   : 1;
   localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
   localparam int unsigned CntW = $clog2(MaxTrans + 1);

   typedef logic [IdW-1:0]  id_t;
   typedef logic [PtrW-1:0] ptr_t;

   id_t              r_rr;
   logic             r_lock;
   id_t              r_lock_idx;
   id_t              r_fifo [MaxTrans];
   ptr_t             r_wptr;
   ptr_t             r_rptr;
   logic [CntW-1:0]  r_cnt;

   logic              w_full;
   logic [NumMgr-1:0] w_elig;
   logic              w_any;
   logic              w_found;
   id_t               w_cand;
   id_t               w_sel;
   logic              w_hs;
   logic              w_pop;
   logic [NumMgr-1:0] w_gnt;
   logic [NumMgr-1:0] w_rvalid;

   function automatic id_t rr_idx(input id_t base, input int unsigned k);
      int unsigned s;
      s = 32'(base) + k;
      return id_t'(s % NumMgr);
   endfunction

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(MaxTrans - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   // Fullness comes from the registered count only, so a same-cycle pop never re-opens the port.
   assign w_full = (r_cnt == CntW'(MaxTrans));
   assign w_elig = (rst_i || w_full) ? '0 : bus.in_req_i;
   assign w_any  = |w_elig;
   assign w_hs   = w_any & bus.out_gnt_i;
   assign w_pop  = bus.out_rvalid_i & (r_cnt != '0) & ~rst_i;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves a latch.
      w_sel    = r_rr;
      w_found  = 1'b0;
      w_cand   = '0;
      w_gnt    = '0;
      w_rvalid = '0;
      if (r_lock) begin
         w_sel = r_lock_idx;
      end else begin
         for (int unsigned k = 0; k < NumMgr; k++) begin
            w_cand = rr_idx(r_rr, k);
            if (!w_found && w_elig[w_cand]) begin
               w_sel   = w_cand;
               w_found = 1'b1;
            end
         end
      end
      w_gnt[w_sel]               = w_hs;
      w_rvalid[r_fifo[r_rptr]]   = w_pop;
   end

   assign bus.out_req_o   = w_any;
   assign bus.out_addr_o  = bus.in_addr_i[w_sel];
   assign bus.out_we_o    = bus.in_we_i[w_sel];
   assign bus.out_be_o    = bus.in_be_i[w_sel];
   assign bus.out_wdata_o = bus.in_wdata_i[w_sel];
   assign bus.in_gnt_o    = w_gnt;
   assign bus.in_rvalid_o = w_rvalid;
   assign bus.in_rdata_o  = bus.out_rdata_i;
   assign bus.in_err_o    = bus.out_err_i;
   assign unexp_rsp_o     = bus.out_rvalid_i & (r_cnt == '0) & ~rst_i;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rr       <= '0;
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_cnt      <= '0;
      end else begin
         if (w_hs) begin
            r_lock <= 1'b0;
            r_rr   <= rr_idx(w_sel, 1);
            r_wptr <= ptr_inc(r_wptr);
         end else if (w_any) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_sel;
         end
         if (w_pop) r_rptr <= ptr_inc(r_rptr);
         case ({w_hs, w_pop})
            2'b10:   r_cnt <= r_cnt + CntW'(1);
            2'b01:   r_cnt <= r_cnt - CntW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // NOTE: ID storage has no reset; the count and pointers alone decide which entries are live.
   always_ff @(posedge clk_i) begin
      if (w_hs) r_fifo[r_wptr] <= w_sel;
   end

endmodule
